// File: rtl/kbd_event_sequencer.sv
// Folds PS/2 E0/F0 prefixes into single key events, tracks shift/ctrl/caps and counts key presses.
// Optional macro KBD_REPEAT_FILTER_EN drops typematic repeats of the currently held key.
module kbd_event_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic [7:0]       data,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             ev_shift,
  output logic             ev_ctrl,
  output logic             ev_caps,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // Handshake: an event transfers on a rising clk where ev_valid=1 and ev_ready=1;
  // ev_* stay stable while ev_valid=1 and ev_ready=0. ev_ready is ignored when ev_valid=0.
  typedef enum logic [2:0] {IDLE, POP, SETTLE, DECODE, EMIT} state_t;

  state_t        state;
  logic [7:0]    byte_r;
  logic          ext_pend;
  logic          brk_pend;
  logic          shift;
  logic          ctrl;
  logic          caps;
  logic [TW-1:0] timer;

  logic is_shift, is_ctrl, is_caps;
  logic shift_nx, ctrl_nx, caps_nx;
  logic drop;
  logic emit_counts;

  assign is_shift = (byte_r == 8'h12) || (byte_r == 8'h59);
  assign is_ctrl  = (byte_r == 8'h14);
  assign is_caps  = (byte_r == 8'h58);
  assign shift_nx = is_shift ? ~brk_pend : shift;
  assign ctrl_nx  = is_ctrl ? ~brk_pend : ctrl;
  assign caps_nx  = (is_caps && !brk_pend) ? ~caps : caps;

  // Modifier keys never count, regardless of the E0 prefix.
  assign emit_counts = !ev_break && (ev_code != 8'h12) && (ev_code != 8'h59) &&
                       (ev_code != 8'h14) && (ev_code != 8'h58);

`ifdef KBD_REPEAT_FILTER_EN
  logic       held_v;
  logic       held_ext;
  logic [7:0] held_code;
  logic       held_match;

  assign held_match = held_v && (held_ext == ext_pend) && (held_code == byte_r);
  assign drop       = !brk_pend && held_match;
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state       <= IDLE;
      byte_r      <= 8'h00;
      ext_pend    <= 1'b0;
      brk_pend    <= 1'b0;
      shift       <= 1'b0;
      ctrl        <= 1'b0;
      caps        <= 1'b0;
      timer       <= '0;
      nextdata_n  <= 1'b1;
      ev_valid    <= 1'b0;
      ev_code     <= 8'h00;
      ev_ext      <= 1'b0;
      ev_break    <= 1'b0;
      ev_shift    <= 1'b0;
      ev_ctrl     <= 1'b0;
      ev_caps     <= 1'b0;
      press_count <= '0;
      err         <= 1'b0;
`ifdef KBD_REPEAT_FILTER_EN
      held_v      <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= 8'h00;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (overflow) begin
            err      <= 1'b1;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            timer    <= '0;
          end else if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end else if (ext_pend || brk_pend) begin
            // A prefix with no follow-up byte is stale; discard it.
            if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
              timer    <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          state      <= SETTLE;
        end
        SETTLE: state <= DECODE;
        DECODE: begin
          timer <= '0;
          if (byte_r == 8'hE0) begin
            ext_pend <= 1'b1;
            state    <= IDLE;
          end else if (byte_r == 8'hF0) begin
            brk_pend <= 1'b1;
            state    <= IDLE;
          end else if (drop) begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            state    <= IDLE;
          end else begin
            shift    <= shift_nx;
            ctrl     <= ctrl_nx;
            caps     <= caps_nx;
            ev_code  <= byte_r;
            ev_ext   <= ext_pend;
            ev_break <= brk_pend;
            ev_shift <= shift_nx;
            ev_ctrl  <= ctrl_nx;
            ev_caps  <= caps_nx;
            ev_valid <= 1'b1;
            state    <= EMIT;
`ifdef KBD_REPEAT_FILTER_EN
            if (!brk_pend) begin
              held_v    <= 1'b1;
              held_ext  <= ext_pend;
              held_code <= byte_r;
            end else if (held_match) begin
              held_v <= 1'b0;
            end
`endif
          end
        end
        EMIT: begin
          if (ev_ready) begin
            ev_valid <= 1'b0;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
            if (emit_counts) press_count <= press_count + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_event_sequencer.sv
// Scoreboard bench for kbd_event_sequencer: a queue-backed receiver FIFO model feeds
// directed byte streams; a monitor pops hand-computed expected events on each transfer.
module tb_kbd_event_sequencer;

  localparam int TO = 16;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clrn = 1'b0;
  logic          ready = 1'b0;
  logic [7:0]    data = 8'h00;
  logic          overflow = 1'b0;
  logic          ev_ready = 1'b1;
  logic          nextdata_n;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ext, ev_break, ev_shift, ev_ctrl, ev_caps;
  logic [CW-1:0] press_count;
  logic          err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  logic [7:0]  fifo_q[$];
  logic [12:0] exp_q[$];
  logic [12:0] mon_e;
  logic [7:0]  popped;

  kbd_event_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .clrn(clrn), .ready(ready), .data(data), .overflow(overflow),
    .nextdata_n(nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_shift(ev_shift),
    .ev_ctrl(ev_ctrl), .ev_caps(ev_caps), .press_count(press_count), .err(err)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver FIFO model: pops and presents the head byte on the falling edge
  always @(negedge clk) begin
    if (!nextdata_n) begin
      pulses = pulses + 1;
      if (fifo_q.size() > 0) popped = fifo_q.pop_front();
    end
    ready = (fifo_q.size() > 0);
    data  = ready ? fifo_q[0] : 8'h00;
  end

  function automatic logic [12:0] ev(input logic [7:0] code, input logic ext, input logic brk,
                                     input logic sh, input logic ct, input logic cp);
    return {code, ext, brk, sh, ct, cp};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an event transfers at the next rising edge when valid and ready are both high
  always @(negedge clk) begin
    if (clrn && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got %0h expected none",
                 {ev_code, ev_ext, ev_break, ev_shift, ev_ctrl, ev_caps});
      end else begin
        mon_e = exp_q.pop_front();
        check("event", {19'h0, ev_code, ev_ext, ev_break, ev_shift, ev_ctrl, ev_caps},
              {19'h0, mon_e});
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #2;
    fifo_q.push_back(b);
  endtask

  task automatic set_ev_ready(input logic v);
    @(posedge clk);
    #2;
    ev_ready = v;
  endtask

  task automatic drain();
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || ev_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (6) tick();
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ev_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_nextdata_n"}, 32'(nextdata_n), 32'h1);
    check({tag, "_ev_valid"}, 32'(ev_valid), 32'h0);
    check({tag, "_ev_fields"}, {19'h0, ev_code, ev_ext, ev_break, ev_shift, ev_ctrl, ev_caps}, 32'h0);
    check({tag, "_count"}, 32'(press_count), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    int p0, t0, t1, n;
    logic stable;

    repeat (3) tick();
    check_reset("reset");
    @(posedge clk);
    #2 clrn = 1'b1;

    // Single make: latency, single pop pulse, count
    p0 = pulses;
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    push(8'h1C);
    n = 0;
    while (!ready && n < 10) begin tick(); n++; end
    t0 = cyc;
    n = 0;
    while (!ev_valid && n < 20) begin tick(); n++; end
    t1 = cyc;
    check("latency", 32'(t1 - t0), 32'd4);
    drain();
    check("pulses_1c", 32'(pulses - p0), 32'd1);
    check("count_1c", 32'(press_count), 32'd1);

    // Extended break folds three bytes into one event
    p0 = pulses;
    exp_q.push_back(ev(8'h75, 1, 1, 0, 0, 0));
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    check("pulses_e0f075", 32'(pulses - p0), 32'd3);
    check("count_ext_break", 32'(press_count), 32'd1);

    // Shift tracking
    exp_q.push_back(ev(8'h12, 0, 0, 1, 0, 0));
    exp_q.push_back(ev(8'h1C, 0, 0, 1, 0, 0));
    exp_q.push_back(ev(8'h1C, 0, 1, 1, 0, 0));
    exp_q.push_back(ev(8'h12, 0, 1, 0, 0, 0));
    push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
    drain();
    check("count_shift", 32'(press_count), 32'd2);

    // Caps toggles on make only
    exp_q.push_back(ev(8'h58, 0, 0, 0, 0, 1));
    exp_q.push_back(ev(8'h58, 0, 1, 0, 0, 1));
    exp_q.push_back(ev(8'h58, 0, 0, 0, 0, 0));
    push(8'h58); push(8'hF0); push(8'h58); push(8'h58);
    drain();
    check("count_caps", 32'(press_count), 32'd2);

    // Backpressure holds the event and stalls the FIFO
    set_ev_ready(1'b0);
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    exp_q.push_back(ev(8'h22, 0, 0, 0, 0, 0));
    push(8'h1C); push(8'h22);
    wait_valid();
    stable = 1'b1;
    repeat (20) begin
      tick();
      stable &= ev_valid && (ev_code == 8'h1C) && !ev_break && nextdata_n && ready;
    end
    check("backpressure_hold", 32'(stable), 32'h1);
    set_ev_ready(1'b1);
    drain();
    check("count_backpressure", 32'(press_count), 32'd4);

    // Stale E0 times out
    push(8'hE0);
    drain();
    repeat (TO + 4) tick();
    exp_q.push_back(ev(8'h75, 0, 0, 0, 0, 0));
    push(8'h75);
    drain();
    check("count_timeout", 32'(press_count), 32'd5);

    // Overflow sets sticky err and discards a pending F0
    check("err_before_overflow", 32'(err), 32'h0);
    push(8'hF0);
    repeat (5) tick();
    @(posedge clk);
    #2 overflow = 1'b1;
    @(posedge clk);
    #2 overflow = 1'b0;
    tick();
    check("err_set", 32'(err), 32'h1);
    exp_q.push_back(ev(8'h1D, 0, 0, 0, 0, 0));
    push(8'h1D);
    drain();
    check("err_sticky", 32'(err), 32'h1);
    check("count_overflow", 32'(press_count), 32'd6);

    // Ctrl, with and without E0
    exp_q.push_back(ev(8'h14, 1, 0, 0, 1, 0));
    exp_q.push_back(ev(8'h21, 0, 0, 0, 1, 0));
    exp_q.push_back(ev(8'h14, 1, 1, 0, 0, 0));
    push(8'hE0); push(8'h14); push(8'h21); push(8'hE0); push(8'hF0); push(8'h14);
    drain();
    check("count_ctrl", 32'(press_count), 32'd7);

    // Typematic repeat; the count also wraps through all-ones here
`ifdef KBD_REPEAT_FILTER_EN
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain();
    check("count_repeat_filtered", 32'(press_count), 32'd0);
`else
    for (int i = 0; i < 3; i++) exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain();
    check("count_repeat_wrap", 32'(press_count), 32'd2);
`endif

    // Reset while an event is held in EMIT
    set_ev_ready(1'b0);
    push(8'hE0); push(8'h14);
    wait_valid();
    check("held_ctrl_event", {19'h0, ev_code, ev_ext, ev_break, ev_shift, ev_ctrl, ev_caps},
          {19'h0, ev(8'h14, 1, 0, 0, 1, 0)});
    @(posedge clk);
    #2 clrn = 1'b0;
    repeat (2) tick();
    check_reset("mid_emit_reset");
    @(posedge clk);
    #2 clrn = 1'b1;
    set_ev_ready(1'b1);
    exp_q.push_back(ev(8'h1C, 0, 0, 0, 0, 0));
    push(8'h1C);
    drain();
    check("count_after_reset", 32'(press_count), 32'd1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/kbd_event_sequencer.md
Name: kbd_event_sequencer

Overview:
- Sits between the PS/2 receiver FIFO and the scan-code-to-ASCII stage.
- Pops raw bytes from the receiver using a ready/nextdata_n handshake and folds E0/F0 prefixes into single key events.
- Tracks shift, ctrl and caps modifier state and presents one event at a time to the downstream consumer over a valid/ready handshake.
- Counts non-modifier key presses.

Parameters:
- TIMEOUT_CYCLES, 50000: maximum idle cycles allowed after a prefix byte before the pending prefix is discarded.
- CNT_W, 8: width of press_count.

Ports:
- clk  in  1  system clock.
- clrn  in  1  synchronous active-low reset, sampled on rising clk.
- ready  in  1  receiver FIFO non-empty.
- data  in  8  receiver FIFO head byte.
- overflow  in  1  receiver FIFO overflow flag.
- nextdata_n  out  1  active-low pop strobe to the receiver.
- ev_valid  out  1  event present.
- ev_ready  in  1  downstream accepts the event.
- ev_code  out  8  base scan code.
- ev_ext  out  1  E0-prefixed key.
- ev_break  out  1  key release.
- ev_shift  out  1  shift held, sampled at event build.
- ev_ctrl  out  1  ctrl held.
- ev_caps  out  1  caps-lock latched.
- press_count  out  CNT_W  non-modifier make events emitted.
- err  out  1  sticky overflow-seen flag.

Behaviour:
- Reset (clrn=0 at rising clk): state=IDLE. nextdata_n=1, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_shift=0, ev_ctrl=0, ev_caps=0, press_count=0, err=0. Internal ext_pend, brk_pend, shift, ctrl, caps and timer all 0. Reset mid-handshake abandons any event or prefix.
- FSM states: IDLE, POP, SETTLE, DECODE, EMIT.
- IDLE:
  - overflow=1 takes priority: err<=1, ext_pend<=0, brk_pend<=0, stay IDLE.
  - Otherwise, if ready=1: byte_r<=data, go to POP.
  - Otherwise, if a prefix is pending: timer increments. When timer reaches TIMEOUT_CYCLES-1, clear both pend flags and the timer.
- POP: nextdata_n=0 for exactly this one cycle, then go to SETTLE. nextdata_n is low only while in POP.
- SETTLE: one dead cycle so ready reflects the post-pop FIFO state. Then go to DECODE.
- DECODE (timer cleared):
  - byte_r=E0: ext_pend<=1, go to IDLE.
  - byte_r=F0: brk_pend<=1, go to IDLE.
  - Otherwise, update modifiers:
    - 12/59 (left/right shift): shift<=~brk_pend.
    - 14 (with or without E0): ctrl<=~brk_pend.
    - 58 make: caps toggles. 58 break has no effect on caps.
  - Then load ev_* with byte_r, ext_pend, brk_pend and the post-update modifier values. ev_valid<=1, go to EMIT.
- EMIT: hold all ev_* stable while ev_valid=1 and ev_ready=0. On ev_ready=1:
  - ev_valid<=0.
  - Clear ext_pend and brk_pend.
  - If the event is a make of a non-modifier key (not 12/59/14/58), press_count<=press_count+1, wrapping from all-ones to 0.
  - Go to IDLE.
- ev_ready while ev_valid=0 is ignored. No new byte is popped while in EMIT; backpressure stalls the receiver FIFO.
- Latency: 4 cycles from ready=1 in IDLE to ev_valid=1 (IDLE, POP, SETTLE, DECODE).
- Consecutive prefixes: E0 then F0 then code yields ext=1, break=1. A duplicate prefix is idempotent.
- err clears only on reset.

Optional Feature:
- Macro: KBD_REPEAT_FILTER_EN.
- Defined:
  - A held register {held_ext, held_code, held_v} is loaded on every emitted non-break event.
  - In DECODE, a make whose {ext, code} equals the held key while held_v=1 is dropped: no event, no count, caps does not toggle, pend flags cleared, go to IDLE.
  - A break of the held key clears held_v.
- Undefined: every typematic make is emitted and counted, and each 58 make toggles caps.

Test Plan:
- Byte 1C, ev_ready tied 1 → one event {code=1C, ext=0, brk=0}. nextdata_n low for exactly 1 cycle. ev_valid rises 4 cycles after ready. press_count=1.
- Bytes E0,F0,75 → single event {code=75, ext=1, brk=1}. press_count unchanged. Exactly 3 nextdata_n pulses.
- Bytes 12,1C,F0,1C,F0,12 → events show shift=1 for 1C make and 1C break, and shift=0 for the final 12 break. press_count=1.
- Byte 58 twice with F0,58 between → caps toggles to 1 then back to 0; ev_caps matches on each event.
- ev_ready held 0 for 20 cycles with 1C pending → ev_* stable, nextdata_n stays 1, ready remains 1. Event drains on ev_ready=1.
- E0 then idle for TIMEOUT_CYCLES → prefix dropped; next byte 75 gives ext=0. Overflow=1 in IDLE → err=1. Mid-EMIT clrn=0 → all outputs return to reset values.
- With KBD_REPEAT_FILTER_EN defined: 1C,1C,1C → one event, press_count=1. Without the macro: three events, press_count=3.
